// File: rtl/pianissimo_pkg.sv
// Shared screen geometry, colour type and renderer FSM encoding for the
// pianissimo video pipeline.
package pianissimo_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;
    localparam int KEY_Y    = 92;

    typedef logic [23:0] colour_t;

    typedef enum logic [1:0] {
        S_SCAN   = 2'd0,
        S_UPDATE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/note_block_renderer_if.sv
// Pixel, spawn and frame-handshake signals between the scanner side (master)
// and the note block renderer (slave).
interface note_block_renderer_if;
    import pianissimo_pkg::*;

    logic       frame_done;
    logic [7:0] inputDrawScreenPosX;
    logic [7:0] inputDrawScreenPosY;
    colour_t    bg_colour;
    logic       spawn_valid;
    logic [2:0] spawn_lane;
    logic [6:0] spawn_len;
    logic       spawn_ready;
    colour_t    outputColour;
    logic       noteBlocksDoneDrawing;
    logic       note_hit;
    logic [2:0] note_hit_lane;

    modport master (
        output frame_done, inputDrawScreenPosX, inputDrawScreenPosY, bg_colour,
        output spawn_valid, spawn_lane, spawn_len,
        input  spawn_ready, outputColour, noteBlocksDoneDrawing, note_hit, note_hit_lane
    );

    modport slave (
        input  frame_done, inputDrawScreenPosX, inputDrawScreenPosY, bg_colour,
        input  spawn_valid, spawn_lane, spawn_len,
        output spawn_ready, outputColour, noteBlocksDoneDrawing, note_hit, note_hit_lane
    );

endinterface

// File: rtl/lane_hit_test.sv
// Combinational test of whether scan row y falls inside one lane's note block,
// whose rows run from bot-len+1 up to bot.
module lane_hit_test (
    input  logic [7:0] i_y,
    input  logic [8:0] i_bot,
    input  logic [6:0] i_len,
    input  logic       i_active,
    output logic       o_hit
);

    logic [9:0] w_y;
    logic [9:0] w_bot;
    logic [9:0] w_y_plus_len;

    // Widened so y + len never wraps; the top-edge test avoids a signed subtract.
    assign w_y          = {2'b00, i_y};
    assign w_bot        = {1'b0, i_bot};
    assign w_y_plus_len = w_y + {3'b000, i_len};

    assign o_hit = i_active && (w_y <= w_bot) && (w_y_plus_len > w_bot);

endmodule

// File: rtl/note_block_renderer.sv
// Overlays falling note blocks on the scanned pixel stream and advances every
// lane one at a time between frames, reporting blocks that reach the keyboard.
module note_block_renderer #(
    parameter int          NUM_LANES   = 8,
    parameter int          LANE_W      = 20,
    parameter int          KEY_Y       = pianissimo_pkg::KEY_Y,
    parameter int          SPEED       = 2,
    parameter logic [23:0] NOTE_COLOUR = 24'hFFFFFF
) (
    input logic                  clk,
    input logic                  reset,
    note_block_renderer_if.slave bus
);
    import pianissimo_pkg::*;

    localparam int         FIELD_W  = (NUM_LANES * LANE_W < SCREEN_W) ? NUM_LANES * LANE_W : SCREEN_W;
    localparam int         FIELD_H  = (KEY_Y < SCREEN_H) ? KEY_Y : SCREEN_H;
    localparam logic [2:0] LAST_IDX = 3'(NUM_LANES - 1);

    state_t                 r_state;
    state_t                 w_state_next;
    logic [2:0]             r_idx;
    logic [2:0]             w_idx_next;
    logic                   w_done;

    logic [NUM_LANES-1:0]   r_active;
    logic [8:0]             r_bot [NUM_LANES];
    logic [6:0]             r_len [NUM_LANES];

    colour_t                r_colour;
    logic                   r_note_hit;
    logic [2:0]             r_note_hit_lane;

    logic                   w_spawn_ready;
    logic [6:0]             w_spawn_len;
    logic                   w_cur_active;
    logic [8:0]             w_cur_bot;
    logic [6:0]             w_cur_len;
    logic [8:0]             w_nb;
    logic                   w_updating;
    logic                   w_hit_now;
    logic                   w_clear_now;
    logic [NUM_LANES-1:0]   w_lane_draw;
    logic                   w_draw;

    // NOTE: sequential state uses <= so every register updates from the same pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= w_idx_next;
        end
    end

    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_done       = 1'b0;
        unique case (r_state)
            S_SCAN: begin
                if (bus.frame_done) begin
                    w_state_next = S_UPDATE;
                    w_idx_next   = '0;
                end
            end
            S_UPDATE: begin
                w_idx_next = r_idx + 3'd1;
                if (r_idx == LAST_IDX) begin
                    w_state_next = S_DONE;
                    w_idx_next   = '0;
                end
            end
            S_DONE: begin
                w_done       = 1'b1;
                w_state_next = S_SCAN;
            end
            default: w_state_next = S_SCAN;
        endcase
    end

    assign w_spawn_ready = (r_state == S_SCAN) && ({1'b0, bus.spawn_lane} < 4'(NUM_LANES))
                           && !r_active[bus.spawn_lane];
    assign w_spawn_len   = (bus.spawn_len == 7'd0) ? 7'd1 : bus.spawn_len;

    assign w_updating   = (r_state == S_UPDATE);
    assign w_cur_active = r_active[r_idx];
    assign w_cur_bot    = r_bot[r_idx];
    assign w_cur_len    = r_len[r_idx];
    assign w_nb         = w_cur_bot + 9'(SPEED);
    assign w_hit_now    = w_updating && w_cur_active && (w_cur_bot < 9'(KEY_Y)) && (w_nb >= 9'(KEY_Y));
    // Top edge nb-len+1 reaching KEY_Y, rearranged to stay unsigned.
    assign w_clear_now  = ({1'b0, w_nb} + 10'd1) >= (10'(KEY_Y) + {3'b000, w_cur_len});

    // NOTE: lane state is a few flops rather than a RAM, so it is cleared on reset like any register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_active <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                r_bot[i] <= '0;
                r_len[i] <= '0;
            end
        end else begin
            if (bus.spawn_valid && w_spawn_ready) begin
                r_active[bus.spawn_lane] <= 1'b1;
                r_bot[bus.spawn_lane]    <= '0;
                r_len[bus.spawn_lane]    <= w_spawn_len;
            end
            if (w_updating && w_cur_active) begin
                if (w_clear_now) begin
                    r_active[r_idx] <= 1'b0;
                end else begin
                    r_bot[r_idx] <= w_nb;
                end
            end
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic w_rows_hit;

        lane_hit_test u_hit (
            .i_y      (bus.inputDrawScreenPosY),
            .i_bot    (r_bot[l]),
            .i_len    (r_len[l]),
            .i_active (r_active[l]),
            .o_hit    (w_rows_hit)
        );

        // Column l*LANE_W is the separator, so the lane body starts one pixel in.
        assign w_lane_draw[l] = w_rows_hit
                                && (int'(bus.inputDrawScreenPosX) > l * LANE_W)
                                && (int'(bus.inputDrawScreenPosX) < (l + 1) * LANE_W);
    end

    assign w_draw = (|w_lane_draw)
                    && (int'(bus.inputDrawScreenPosX) < FIELD_W)
                    && (int'(bus.inputDrawScreenPosY) < FIELD_H);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_colour        <= '0;
            r_note_hit      <= 1'b0;
            r_note_hit_lane <= '0;
        end else begin
            r_colour   <= w_draw ? NOTE_COLOUR : bus.bg_colour;
            r_note_hit <= w_hit_now;
            if (w_hit_now) begin
                r_note_hit_lane <= r_idx;
            end
        end
    end

    assign bus.spawn_ready           = w_spawn_ready;
    assign bus.outputColour          = r_colour;
    assign bus.noteBlocksDoneDrawing = w_done;
    assign bus.note_hit              = r_note_hit;
    assign bus.note_hit_lane         = r_note_hit_lane;

endmodule

// File: tb/tb_note_block_renderer.sv
// Randomized self-checking bench for note_block_renderer against a lane-level
// reference model of block positions, frame updates and pixel compositing.
module tb_note_block_renderer;
    import pianissimo_pkg::*;

    localparam int      NUM_LANES = 8;
    localparam int      LANE_W    = 20;
    localparam int      SPEED     = 2;
    localparam colour_t NOTE      = 24'hFFFFFF;

    typedef struct {
        int x;
        int y;
        bit note;
    } pt_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    note_block_renderer_if bus ();

    note_block_renderer #(
        .NUM_LANES   (NUM_LANES),
        .LANE_W      (LANE_W),
        .KEY_Y       (KEY_Y),
        .SPEED       (SPEED),
        .NOTE_COLOUR (NOTE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int hit_total;
    int last_hit_frame;
    int frame_no = 0;

    bit m_active [NUM_LANES];
    int m_bot    [NUM_LANES];
    int m_len    [NUM_LANES];

    function automatic colour_t model_pixel(input int x, input int y, input colour_t bg);
        int lane;
        int top;
        lane = x / LANE_W;
        if (x >= NUM_LANES * LANE_W || x % LANE_W == 0 || y >= KEY_Y) return bg;
        if (!m_active[lane]) return bg;
        top = m_bot[lane] - m_len[lane] + 1;
        if (y < top || y > m_bot[lane]) return bg;
        return NOTE;
    endfunction

    function automatic colour_t rand_bg();
        return {1'b0, 23'($urandom)};
    endfunction

    task automatic model_clear();
        for (int l = 0; l < NUM_LANES; l++) begin
            m_active[l] = 1'b0;
            m_bot[l]    = 0;
            m_len[l]    = 0;
        end
    endtask

    task automatic idle_inputs();
        bus.frame_done          = 1'b0;
        bus.spawn_valid         = 1'b0;
        bus.spawn_lane          = 3'd0;
        bus.spawn_len           = 7'd0;
        bus.inputDrawScreenPosX = 8'd0;
        bus.inputDrawScreenPosY = 8'd0;
        bus.bg_colour           = 24'd0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_clear();
        @(negedge clk);
    endtask

    task automatic sample_pixel(input int x, input int y, input colour_t bg, output colour_t got);
        bus.inputDrawScreenPosX = 8'(x);
        bus.inputDrawScreenPosY = 8'(y);
        bus.bg_colour           = bg;
        @(negedge clk);
        got = bus.outputColour;
    endtask

    task automatic do_spawn(input int lane, input int len);
        bit exp_ready;
        exp_ready       = !m_active[lane];
        bus.spawn_valid = 1'b1;
        bus.spawn_lane  = 3'(lane);
        bus.spawn_len   = 7'(len);
        #1;
        n_checks++;
        if (bus.spawn_ready !== exp_ready) begin
            n_fail++;
            $display("FAIL spawn_ready lane %0d: got %b expected %b", lane, bus.spawn_ready, exp_ready);
        end
        if (exp_ready) begin
            m_active[lane] = 1'b1;
            m_bot[lane]    = 0;
            m_len[lane]    = (len == 0) ? 1 : len;
        end
        @(negedge clk);
        bus.spawn_valid = 1'b0;
    endtask

    // Pulses frame_done, steps the model one frame and checks hit and done timing.
    task automatic run_frame(input bit sp_en, input int sp_lane, input int sp_len, input bit probe_busy);
        bit exp_hit [NUM_LANES];
        bit exp_h;
        bit exp_d;
        bit exp_ready;
        int nb;
        bus.frame_done = 1'b1;
        if (sp_en) begin
            exp_ready       = !m_active[sp_lane];
            bus.spawn_valid = 1'b1;
            bus.spawn_lane  = 3'(sp_lane);
            bus.spawn_len   = 7'(sp_len);
            #1;
            n_checks++;
            if (bus.spawn_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL spawn_with_frame ready lane %0d: got %b expected %b", sp_lane, bus.spawn_ready, exp_ready);
            end
            if (exp_ready) begin
                m_active[sp_lane] = 1'b1;
                m_bot[sp_lane]    = 0;
                m_len[sp_lane]    = (sp_len == 0) ? 1 : sp_len;
            end
        end
        frame_no++;
        for (int l = 0; l < NUM_LANES; l++) begin
            exp_hit[l] = 1'b0;
            if (m_active[l]) begin
                nb = m_bot[l] + SPEED;
                if (m_bot[l] < KEY_Y && nb >= KEY_Y) exp_hit[l] = 1'b1;
                if (nb - m_len[l] + 1 >= KEY_Y) m_active[l] = 1'b0;
                else m_bot[l] = nb;
            end
        end
        for (int k = 1; k <= NUM_LANES + 3; k++) begin
            @(negedge clk);
            if (k == 1) begin
                bus.frame_done  = 1'b0;
                bus.spawn_valid = 1'b0;
            end
            exp_h = 1'b0;
            if (k >= 2 && k <= NUM_LANES + 1) exp_h = exp_hit[k-2];
            exp_d = (k == NUM_LANES + 1);
            n_checks++;
            if (bus.note_hit !== exp_h) begin
                n_fail++;
                $display("FAIL note_hit frame %0d cycle %0d: got %b expected %b", frame_no, k, bus.note_hit, exp_h);
            end
            if (exp_h) begin
                n_checks++;
                if (bus.note_hit_lane !== 3'(k - 2)) begin
                    n_fail++;
                    $display("FAIL note_hit_lane frame %0d: got %0d expected %0d", frame_no, bus.note_hit_lane, k - 2);
                end
            end
            if (bus.note_hit === 1'b1) begin
                hit_total++;
                last_hit_frame = frame_no;
            end
            n_checks++;
            if (bus.noteBlocksDoneDrawing !== exp_d) begin
                n_fail++;
                $display("FAIL done_pulse frame %0d cycle %0d: got %b expected %b", frame_no, k, bus.noteBlocksDoneDrawing, exp_d);
            end
            if (probe_busy && k <= NUM_LANES) begin
                bus.spawn_valid = 1'b1;
                bus.spawn_lane  = 3'(k - 1);
                bus.spawn_len   = 7'd9;
                #1;
                n_checks++;
                if (bus.spawn_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL spawn_during_update lane %0d: got %b expected 0", k - 1, bus.spawn_ready);
                end
            end
            if (k == NUM_LANES + 1) bus.spawn_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle_inputs();
        model_clear();
        #2;
        n_checks++;
        if (bus.outputColour !== 24'd0) begin
            n_fail++;
            $display("FAIL reset outputColour: got %h expected 000000", bus.outputColour);
        end
        n_checks++;
        if (bus.noteBlocksDoneDrawing !== 1'b0) begin
            n_fail++;
            $display("FAIL reset done: got %b expected 0", bus.noteBlocksDoneDrawing);
        end
        n_checks++;
        if (bus.note_hit !== 1'b0 || bus.note_hit_lane !== 3'd0) begin
            n_fail++;
            $display("FAIL reset note_hit: got %b/%0d expected 0/0", bus.note_hit, bus.note_hit_lane);
        end
        for (int l = 0; l < NUM_LANES; l += 7) begin
            bus.spawn_lane = 3'(l);
            #1;
            n_checks++;
            if (bus.spawn_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL reset spawn_ready lane %0d: got %b expected 1", l, bus.spawn_ready);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_background();
        colour_t bg;
        colour_t got;
        do_reset();
        hit_total = 0;
        for (int y = 0; y < SCREEN_H; y++) begin
            for (int x = 0; x < SCREEN_W; x++) begin
                bg = 24'($urandom);
                sample_pixel(x, y, bg, got);
                n_checks++;
                if (got !== bg) begin
                    n_fail++;
                    $display("FAIL background (%0d,%0d): got %h expected %h", x, y, got, bg);
                end
            end
        end
        for (int f = 0; f < 3; f++) begin
            run_frame(1'b0, 0, 0, 1'b0);
            for (int i = 0; i < 20; i++) begin
                bg = 24'($urandom);
                sample_pixel($urandom_range(0, SCREEN_W - 1), $urandom_range(0, SCREEN_H - 1), bg, got);
                n_checks++;
                if (got !== bg) begin
                    n_fail++;
                    $display("FAIL background after frame %0d: got %h expected %h", f, got, bg);
                end
            end
        end
        n_checks++;
        if (hit_total != 0) begin
            n_fail++;
            $display("FAIL background hits: got %0d expected 0", hit_total);
        end
    endtask

    task automatic test_lane2_len10();
        pt_t     pts [$];
        colour_t bg;
        colour_t got;
        colour_t exp;
        do_reset();
        do_spawn(2, 10);
        run_frame(1'b0, 0, 0, 1'b0);
        for (int x = 41; x <= 59; x++)
            for (int y = 0; y <= 2; y++) pts.push_back('{x, y, 1'b1});
        pts.push_back('{40, 1, 1'b0});
        pts.push_back('{41, 3, 1'b0});
        pts.push_back('{60, 1, 1'b0});
        pts.push_back('{21, 1, 1'b0});
        foreach (pts[i]) begin
            bg = rand_bg();
            sample_pixel(pts[i].x, pts[i].y, bg, got);
            exp = pts[i].note ? NOTE : bg;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL lane2 pixel (%0d,%0d): got %h expected %h", pts[i].x, pts[i].y, got, exp);
            end
        end
    endtask

    task automatic test_hit_lane0();
        int      start;
        colour_t bg;
        colour_t got;
        do_reset();
        hit_total = 0;
        last_hit_frame = -1;
        do_spawn(0, 4);
        start = frame_no;
        for (int f = 0; f < 47; f++) run_frame(1'b0, 0, 0, 1'b0);
        n_checks++;
        if (hit_total != 1 || last_hit_frame != start + 46) begin
            n_fail++;
            $display("FAIL lane0 hit count/frame: got %0d at %0d expected 1 at %0d", hit_total, last_hit_frame - start, 46);
        end
        bus.spawn_lane = 3'd0;
        #1;
        n_checks++;
        if (bus.spawn_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lane0 still active at bot 94: ready got %b expected 0", bus.spawn_ready);
        end
        bg = rand_bg();
        sample_pixel(1, 91, bg, got);
        n_checks++;
        if (got !== NOTE) begin
            n_fail++;
            $display("FAIL lane0 row 91 at bot 94: got %h expected %h", got, NOTE);
        end
        run_frame(1'b0, 0, 0, 1'b0);
        bus.spawn_lane = 3'd0;
        #1;
        n_checks++;
        if (bus.spawn_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL lane0 cleared: ready got %b expected 1", bus.spawn_ready);
        end
        bg = rand_bg();
        sample_pixel(1, 91, bg, got);
        n_checks++;
        if (got !== bg) begin
            n_fail++;
            $display("FAIL lane0 row 91 after clear: got %h expected %h", got, bg);
        end
        n_checks++;
        if (hit_total != 1) begin
            n_fail++;
            $display("FAIL lane0 total hits: got %0d expected 1", hit_total);
        end
    endtask

    task automatic test_spawn_rules();
        pt_t     pts [$];
        colour_t bg;
        colour_t got;
        colour_t exp;
        do_reset();
        do_spawn(5, 8);
        bus.spawn_valid = 1'b1;
        bus.spawn_lane  = 3'd5;
        bus.spawn_len   = 7'd3;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++;
            if (bus.spawn_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL busy lane 5 cycle %0d: ready got %b expected 0", c, bus.spawn_ready);
            end
            @(negedge clk);
        end
        bus.spawn_valid = 1'b0;
        run_frame(1'b0, 0, 0, 1'b1);
        do_spawn(6, 0);
        run_frame(1'b0, 0, 0, 1'b0);
        pts.push_back('{121, 2, 1'b1});
        pts.push_back('{139, 2, 1'b1});
        pts.push_back('{121, 1, 1'b0});
        pts.push_back('{121, 3, 1'b0});
        pts.push_back('{101, 0, 1'b1});
        pts.push_back('{101, 4, 1'b1});
        pts.push_back('{101, 5, 1'b0});
        foreach (pts[i]) begin
            bg = rand_bg();
            sample_pixel(pts[i].x, pts[i].y, bg, got);
            exp = pts[i].note ? NOTE : bg;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL spawn_rules pixel (%0d,%0d): got %h expected %h", pts[i].x, pts[i].y, got, exp);
            end
        end
    endtask

    task automatic test_spawn_with_frame();
        pt_t     pts [$];
        colour_t bg;
        colour_t got;
        colour_t exp;
        do_reset();
        run_frame(1'b1, 3, 5, 1'b0);
        pts.push_back('{61, 2, 1'b1});
        pts.push_back('{61, 0, 1'b1});
        pts.push_back('{61, 3, 1'b0});
        pts.push_back('{60, 2, 1'b0});
        foreach (pts[i]) begin
            bg = rand_bg();
            sample_pixel(pts[i].x, pts[i].y, bg, got);
            exp = pts[i].note ? NOTE : bg;
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL same_cycle_spawn pixel (%0d,%0d): got %h expected %h", pts[i].x, pts[i].y, got, exp);
            end
        end
    endtask

    task automatic test_reset_mid_update();
        int      n_done;
        colour_t bg;
        colour_t got;
        do_reset();
        do_spawn(1, 30);
        run_frame(1'b0, 0, 0, 1'b0);
        bus.inputDrawScreenPosX = 8'd21;
        bus.inputDrawScreenPosY = 8'd1;
        bus.bg_colour           = rand_bg();
        bus.frame_done          = 1'b1;
        @(negedge clk);
        bus.frame_done = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.outputColour !== NOTE) begin
            n_fail++;
            $display("FAIL pre-reset block pixel: got %h expected %h", bus.outputColour, NOTE);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if (bus.outputColour !== 24'd0 || bus.noteBlocksDoneDrawing !== 1'b0
            || bus.note_hit !== 1'b0 || bus.note_hit_lane !== 3'd0) begin
            n_fail++;
            $display("FAIL mid-update reset outputs: got %h/%b/%b/%0d expected 000000/0/0/0",
                     bus.outputColour, bus.noteBlocksDoneDrawing, bus.note_hit, bus.note_hit_lane);
        end
        bus.spawn_lane = 3'd1;
        #1;
        n_checks++;
        if (bus.spawn_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid-update reset lane 1 ready: got %b expected 1", bus.spawn_ready);
        end
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        n_done = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (bus.noteBlocksDoneDrawing === 1'b1) n_done++;
        end
        n_checks++;
        if (n_done != 0) begin
            n_fail++;
            $display("FAIL done after reset: got %0d pulses expected 0", n_done);
        end
        bg = rand_bg();
        sample_pixel(21, 1, bg, got);
        n_checks++;
        if (got !== bg) begin
            n_fail++;
            $display("FAIL block lost on reset: got %h expected %h", got, bg);
        end
    endtask

    task automatic test_random();
        int      lane;
        int      len;
        int      x;
        int      y;
        colour_t bg;
        colour_t got;
        colour_t exp;
        do_reset();
        for (int it = 0; it < 80; it++) begin
            lane = $urandom_range(0, NUM_LANES - 1);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 127) : $urandom_range(0, 12);
            case ($urandom_range(0, 3))
                0: begin
                    do_spawn(lane, len);
                    run_frame(1'b0, 0, 0, 1'b0);
                end
                1: run_frame(1'b1, lane, len, 1'b0);
                default: run_frame(1'b0, 0, 0, (it % 5) == 0);
            endcase
            for (int i = 0; i < 30; i++) begin
                x  = $urandom_range(0, SCREEN_W - 1);
                y  = $urandom_range(0, 99);
                bg = 24'($urandom);
                exp = model_pixel(x, y, bg);
                sample_pixel(x, y, bg, got);
                n_checks++;
                if (got !== exp) begin
                    n_fail++;
                    $display("FAIL random pixel (%0d,%0d) iter %0d: got %h expected %h", x, y, it, got, exp);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_background();
        test_lane2_len10();
        test_hit_lane0();
        test_spawn_rules();
        test_spawn_with_frame();
        test_reset_mid_update();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/note_block_renderer.md
# note_block_renderer

Overlays falling note blocks on the frame pixel stream, between the screen scanner and the VGA write port. For each scanned pixel it combines the scanner position with the background colour (black note field above row 92, piano image below) and outputs either a lane note colour or the background. Between frames it advances every active block, reports blocks reaching the keyboard line, and then pulses `noteBlocksDoneDrawing`, which releases the piano-address advance in the background stage.

## Interface
- `NUM_LANES`, default 8: number of note lanes. Must be a power of two, at most 8.
- `LANE_W`, default 20: lane width in pixels. `NUM_LANES*LANE_W` must be at most 160.
- `KEY_Y`, default 92: first keyboard row; notes are drawn only at `y < KEY_Y`.
- `SPEED`, default 2: rows each block advances per frame, 1..15.
- `NOTE_COLOUR`, default 24'hFFFFFF: fill colour of note blocks.

- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `frame_done` in 1: one-cycle pulse from the scanner at end of frame.
- `inputDrawScreenPosX` in 8: scan X.
- `inputDrawScreenPosY` in 8: scan Y.
- `bg_colour` in 24: background colour for the current pixel.
- `spawn_valid` in 1: spawn request.
- `spawn_lane` in 3: target lane.
- `spawn_len` in 7: block length in rows; 0 is treated as 1.
- `spawn_ready` out 1: spawn accepted this cycle.
- `outputColour` out 24: composited colour, registered.
- `noteBlocksDoneDrawing` out 1: one-cycle pulse when the inter-frame update is complete.
- `note_hit` out 1: one-cycle pulse when a block bottom reaches `KEY_Y`.
- `note_hit_lane` out 3: lane of the current hit; valid only while `note_hit` is high.

## Operation
- Per-lane state: `active` (1 bit), `bot` (9 bits, row of the block bottom edge), `len` (7 bits).
- FSM states:
  - S_SCAN: entered on reset. On `frame_done`, go to S_UPDATE with `idx=0`.
  - S_UPDATE: process lane `idx` (one lane per cycle), then increment `idx`. After lane `NUM_LANES-1`, go to S_DONE.
  - S_DONE: assert `noteBlocksDoneDrawing` for one cycle, then go to S_SCAN.
- Lane update, when the lane is active:
  - Compute `nb = bot + SPEED` in 9 bits; this cannot overflow.
  - If `bot < KEY_Y` and `nb >= KEY_Y`, pulse `note_hit` and set `note_hit_lane = idx`.
  - If `nb - len + 1 >= KEY_Y`, clear `active`: the block has fully passed the keyboard line.
  - Otherwise set `bot = nb`.
  - Inactive lanes are skipped, and still take one cycle.
- Spawn:
  - `spawn_ready = (state == S_SCAN) && spawn_lane < NUM_LANES && !active[spawn_lane]`.
  - On `spawn_valid && spawn_ready`: set `active`, `bot = 0`, `len = max(spawn_len, 1)`.
  - If the lane is busy, the request stays unaccepted; the requester must hold it.
- Pixel path, evaluated every cycle:
  - `lane = x / LANE_W`.
  - Output `NOTE_COLOUR` when all of these hold:
    - `x < NUM_LANES*LANE_W`;
    - `x % LANE_W != 0` (1-px lane separator);
    - `y < KEY_Y`;
    - `active[lane]`;
    - `y <= bot` and `y + len > bot`.
  - Otherwise output `bg_colour`.
  - Rows of a block above 0 are implicitly clipped.

## Timing
- Reset values:
  - FSM in S_SCAN, `idx = 0`;
  - all `active = 0`, `bot = 0`, `len = 0`;
  - `outputColour = 0`, `noteBlocksDoneDrawing = 0`, `note_hit = 0`, `note_hit_lane = 0`;
  - `spawn_ready` follows its equation.
- `outputColour` has 1-cycle latency from the X/Y/`bg_colour` inputs. The scanner's address pipeline must align to this.
- `frame_done` to `noteBlocksDoneDrawing` pulse: exactly `NUM_LANES+1` cycles.
- `frame_done` received outside S_SCAN is ignored.
- Spawn accepted in the same cycle as `frame_done`: the new block is processed in this update, giving `bot = SPEED`.
- `note_hit` is registered: it appears the cycle after its lane is processed. There is at most one hit per cycle.
- Reset mid-update: all blocks are lost, no done pulse is issued, and the FSM restarts in S_SCAN.

## Structure
- Shared package `pianissimo_pkg`:
  - screen constants `SCREEN_W = 160`, `SCREEN_H = 120`, `KEY_Y = 92`;
  - colour type (24-bit);
  - FSM state encoding.
- One sub-module, `lane_hit_test`: combinational pixel-in-block test. Inputs are y, `bot`, `len`, `active`; output is hit.

## Test plan
- Reset, no spawns, 3 frames: output equals `bg_colour` one cycle later for every pixel, `note_hit` is never asserted, and each `frame_done` is followed 9 cycles later by a done pulse.
- Spawn lane 2, len 10, then 1 frame: with `SPEED = 2`, `bot = 2`. Pixels (41..59, 0..2) are `NOTE_COLOUR`; (40, 1) and (41, 3) are background.
- Lane 0, len 4, advanced 46 frames: `note_hit` with `note_hit_lane = 0` fires exactly once, on the update that moves `bot` from 90 to 92. The block clears on the update with `bot` at 94.
- Spawn while lane 5 is active: `spawn_ready = 0`. Spawn during S_UPDATE: `spawn_ready = 0`. Spawn with len 0: a 1-row block is drawn.
- Spawn in the same cycle as `frame_done`: `bot = 2` after the update. Assert `reset` during S_UPDATE: all outputs return to reset values and no done pulse follows.
